pattern_player: RTL and testbench

PATTERN_PLAYER -- requirements
Module: pattern_player

---
 rtl/pattern_pkg.sv | 17 +
 rtl/slow_tick_sync.sv | 22 ++
 rtl/pattern_player.sv | 115 +++++++++++
 tb/tb_pattern_player.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Shared types and widths for the LED pattern player.
package pattern_pkg;

  localparam int unsigned SEQ_W  = 3;
  localparam int unsigned STEP_W = 5;
  localparam int unsigned LED_W  = 10;
  localparam int unsigned ROM_W  = 11;
  localparam int unsigned ADDR_W = SEQ_W + STEP_W;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWait,
    StShow
  } state_e;

endpackage

// File: rtl/slow_tick_sync.sv
// Two-flop synchroniser for the asynchronous step clock plus rising-edge detector.
module slow_tick_sync (
  input  logic clk_50,
  input  logic reset,
  input  logic slow_clk,
  output logic tick
);

  // [0],[1] synchronise; [2] remembers the previous synchronised level
  logic [2:0] sync_q;

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], slow_clk};
    end
  end

  assign tick = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/pattern_player.sv
// Steps through a ROM-held LED sequence, advancing one step per slow_clk rising edge.
module pattern_player
  import pattern_pkg::*;
(
  input  logic              clk_50,
  input  logic              reset,
  input  logic [SEQ_W-1:0]  seq_num,
  input  logic              slow_clk,
  input  logic              pause,
  input  logic [ROM_W-1:0]  rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [LED_W-1:0]  LEDS,
  output logic [STEP_W-1:0] step
);

  localparam logic [STEP_W-1:0] StepMax = '1;

  logic tick;

  state_e              state_q, state_d;
  logic [SEQ_W-1:0]    seq_q, seq_d;
  logic [STEP_W-1:0]   step_q, step_d, step_next;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LED_W-1:0]    leds_q, leds_d;
  logic                last_q, last_d;
  logic                pending_q, pending_d;
  logic                restart;

  slow_tick_sync u_tick_sync (
    .clk_50   (clk_50),
    .reset    (reset),
    .slow_clk (slow_clk),
    .tick     (tick)
  );

  assign step_next = (last_q || (step_q == StepMax)) ? '0 : step_q + 1'b1;
  assign restart   = (state_q != StIdle) && (seq_num != seq_q);

  always_comb begin
    state_d   = state_q;
    seq_d     = seq_q;
    step_d    = step_q;
    addr_d    = addr_q;
    leds_d    = leds_q;
    last_d    = last_q;
    pending_d = pending_q;

    unique case (state_q)
      StIdle: begin
        seq_d   = seq_num;
        step_d  = '0;
        addr_d  = {seq_num, {STEP_W{1'b0}}};
        state_d = StFetch;
      end
      StFetch: begin
        if (tick) pending_d = 1'b1;
        state_d = StWait;
      end
      StWait: begin
        if (tick) pending_d = 1'b1;
        leds_d  = rom_data[LED_W-1:0];
        last_d  = rom_data[LED_W];
        state_d = StShow;
      end
      StShow: begin
        if (pause) begin
          if (tick) pending_d = 1'b1;
        end else if (tick || pending_q) begin
          // a second tick arriving alongside a pending one is dropped
          pending_d = 1'b0;
          step_d    = step_next;
          addr_d    = {seq_q, step_next};
          state_d   = StFetch;
        end
      end
      default: state_d = StIdle;
    endcase

    // A sequence change beats any tick and discards rom_data still in flight
    if (restart) begin
      seq_d     = seq_num;
      step_d    = '0;
      addr_d    = {seq_num, {STEP_W{1'b0}}};
      pending_d = 1'b0;
      leds_d    = leds_q;
      last_d    = last_q;
      state_d   = StFetch;
    end
  end

  always_ff @(posedge clk_50) begin
    if (!reset) begin
      state_q   <= StIdle;
      seq_q     <= '0;
      step_q    <= '0;
      addr_q    <= '0;
      leds_q    <= '0;
      last_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      seq_q     <= seq_d;
      step_q    <= step_d;
      addr_q    <= addr_d;
      leds_q    <= leds_d;
      last_q    <= last_d;
      pending_q <= pending_d;
    end
  end

  assign rom_addr = addr_q;
  assign LEDS     = leds_q;
  assign step     = step_q;

endmodule

// File: tb/tb_pattern_player.sv
// Self-checking bench for pattern_player: ROM model, table-driven walk and scoreboard.
module tb_pattern_player;

  logic        clk_50;
  logic        reset;
  logic [2:0]  seq_num;
  logic        slow_clk;
  logic        pause;
  logic [10:0] rom_data;
  logic [7:0]  rom_addr;
  logic [9:0]  LEDS;
  logic [4:0]  step;

  pattern_player dut (
    .clk_50   (clk_50),
    .reset    (reset),
    .seq_num  (seq_num),
    .slow_clk (slow_clk),
    .pause    (pause),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .LEDS     (LEDS),
    .step     (step)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  logic [10:0] rom [256];
  always @(posedge clk_50) rom_data <= rom[rom_addr];

  typedef struct {
    int          due;
    logic [4:0]  step;
    logic [7:0]  addr;
    logic [9:0]  leds;
  } sb_t;

  typedef struct {
    logic [2:0] seq;
    logic [4:0] step;
    logic [7:0] addr;
  } vec_t;

  sb_t  sb [$];
  vec_t walk [4];
  int   cyc;
  int   checks;
  int   failures;

  function automatic logic [10:0] rom_word(input int a);
    int         v;
    logic [9:0] p;
    v = (a * 29 + 3) ^ 32'h0F0;
    p = v[9:0];
    if (a == 64) p = 10'h155;
    return {(a == 67), p};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_push(input int due, input logic [4:0] st, input logic [7:0] ad,
                         input logic [9:0] ld);
    sb_t e;
    e.due  = due;
    e.step = st;
    e.addr = ad;
    e.leds = ld;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      chk("sb_missed", 32'(cyc), 32'(e.due));
    end
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("sb_leds", 32'(LEDS), 32'(e.leds));
      chk("sb_step", 32'(step), 32'(e.step));
      chk("sb_addr", 32'(rom_addr), 32'(e.addr));
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled on the falling edge
  task automatic cycle();
    @(posedge clk_50);
    cyc++;
    @(negedge clk_50);
    sb_check();
  endtask

  task automatic pulse(input bit push, input logic [4:0] st, input logic [7:0] ad);
    int k;
    k = cyc;
    slow_clk = 1'b1;
    if (push) sb_push(k + 5, st, ad, rom[ad][9:0]);
    repeat (4) cycle();
    slow_clk = 1'b0;
    repeat (4) cycle();
  endtask

  initial begin
    int k;
    logic [4:0] s;
    for (int a = 0; a < 256; a++) rom[a] = rom_word(a);
    walk[0] = '{seq: 3'd2, step: 5'd1, addr: 8'd65};
    walk[1] = '{seq: 3'd2, step: 5'd2, addr: 8'd66};
    walk[2] = '{seq: 3'd2, step: 5'd3, addr: 8'd67};
    walk[3] = '{seq: 3'd2, step: 5'd0, addr: 8'd64};
    checks = 0;
    failures = 0;
    cyc = 0;
    reset = 1'b0;
    seq_num = 3'd2;
    slow_clk = 1'b0;
    pause = 1'b0;

    repeat (3) cycle();
    chk("reset_leds", 32'(LEDS), 0);
    chk("reset_addr", 32'(rom_addr), 0);
    chk("reset_step", 32'(step), 0);

    reset = 1'b1;
    cycle();
    chk("first_fetch_addr", 32'(rom_addr), 64);
    chk("first_fetch_leds", 32'(LEDS), 0);
    sb_push(cyc + 2, 5'd0, 8'd64, 10'h155);
    repeat (4) cycle();

    // Walk 0..3 then wrap on the last-step flag at address 67
    for (int i = 0; i < 4; i++) begin
      seq_num = walk[i].seq;
      pulse(1'b1, walk[i].step, walk[i].addr);
    end

    // Two ticks while paused collapse into a single advance
    pause = 1'b1;
    pulse(1'b0, 5'd0, 8'd0);
    pulse(1'b0, 5'd0, 8'd0);
    chk("pause_step", 32'(step), 0);
    chk("pause_leds", 32'(LEDS), 32'(rom[64][9:0]));
    pause = 1'b0;
    sb_push(cyc + 3, 5'd1, 8'd65, rom[65][9:0]);
    repeat (10) cycle();
    chk("pause_one_adv", 32'(step), 1);

    // Sequence change coincident with a tick: restart, tick discarded
    k = cyc;
    slow_clk = 1'b1;
    repeat (2) cycle();
    seq_num = 3'd5;
    cycle();
    chk("seqtick_addr", 32'(rom_addr), 160);
    chk("seqtick_step", 32'(step), 0);
    chk("seqtick_leds_hold", 32'(LEDS), 32'(rom[65][9:0]));
    sb_push(k + 5, 5'd0, 8'd160, rom[160][9:0]);
    repeat (3) cycle();
    slow_clk = 1'b0;
    repeat (8) cycle();
    chk("seqtick_no_adv", 32'(step), 0);

    // Reset asserted while in WAIT
    slow_clk = 1'b1;
    repeat (4) cycle();
    reset = 1'b0;
    slow_clk = 1'b0;
    cycle();
    chk("rstwait_leds", 32'(LEDS), 0);
    chk("rstwait_addr", 32'(rom_addr), 0);
    chk("rstwait_step", 32'(step), 0);
    cycle();
    reset = 1'b1;
    cycle();
    chk("rel_fetch_addr", 32'(rom_addr), 160);
    sb_push(cyc + 2, 5'd0, 8'd160, rom[160][9:0]);
    repeat (4) cycle();

    // Sequence change during WAIT must not load the stale ROM word
    slow_clk = 1'b1;
    repeat (4) cycle();
    seq_num = 3'd2;
    slow_clk = 1'b0;
    cycle();
    chk("waitchg_leds", 32'(LEDS), 32'(rom[160][9:0]));
    chk("waitchg_addr", 32'(rom_addr), 64);
    chk("waitchg_step", 32'(step), 0);
    sb_push(cyc + 2, 5'd0, 8'd64, 10'h155);
    repeat (6) cycle();

    // Full walk on a sequence with no last flags: 31 wraps to 0
    seq_num = 3'd3;
    sb_push(cyc + 3, 5'd0, 8'd96, rom[96][9:0]);
    repeat (6) cycle();
    for (int i = 0; i < 32; i++) begin
      s = 5'(i + 1);
      pulse(1'b1, s, 8'(96 + int'(s)));
    end
    repeat (4) cycle();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
